// File: rtl/clk_div_bank_if.sv
// Configuration bus for clk_div_bank.
// Master drives channel writes; slave reports rejected writes.
interface clk_div_bank_if #(
    parameter int NCH  = 4,
    parameter int DIVW = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_en;
    logic            cfg_err;

    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_en,
        input  cfg_err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_en,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock divider / enable generator on CLK10MHZ.
// Divisor changes take effect at period boundaries; sync_restart aligns all.
module clk_div_bank #(
    parameter int             NCH     = 4,
    parameter int             DIVW    = 8,
    parameter int             RST_DIV = 10,
    parameter logic [NCH-1:0] RST_EN  = NCH'(1)
) (
    input  logic             CLK10MHZ,
    input  logic             rst_n,
    clk_div_bank_if.slave    cfg,
    input  logic             sync_restart,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   rise_stb,
    output logic [NCH-1:0]   fall_stb,
    output logic [NCH-1:0]   active,
    output logic [NCH-1:0]   pending
);
    typedef logic [DIVW-1:0] div_t;
    typedef logic [DIVW:0]   dwx_t;

    localparam div_t RST_N  = div_t'(RST_DIV);
    localparam div_t RST_HI = div_t'((RST_DIV + 1) / 2);

    logic [NCH-1:0]           run_q, pv_q, pe_q;
    logic [NCH-1:0][DIVW-1:0] n_q, cnt_q, pd_q;
    logic [NCH-1:0]           clk_q, rise_q, fall_q;
    logic                     err_q;

    logic [NCH-1:0]           run_d, pv_d, pe_d;
    logic [NCH-1:0][DIVW-1:0] n_d, cnt_d, pd_d;
    logic [NCH-1:0]           clk_d, rise_d, fall_d;

    logic [NCH-1:0]           acc, pvw, pew;
    logic [NCH-1:0][DIVW-1:0] pdw;
    logic [NCH-1:0][DIVW:0]   hi_d;
    logic                     in_rng, rej;

    // Next-state of every channel: write merge, start/stop, boundary, restart
    always_comb begin
        in_rng = 32'(cfg.cfg_ch) < NCH;
        rej    = cfg.cfg_we && in_rng && cfg.cfg_en &&
                 (cfg.cfg_div < div_t'(2));
        for (int i = 0; i < NCH; i++) begin
            acc[i] = cfg.cfg_we && in_rng && !rej &&
                     (32'(cfg.cfg_ch) == 32'(i));
            pvw[i] = acc[i] | pv_q[i];
            pew[i] = acc[i] ? cfg.cfg_en : pe_q[i];
            pdw[i] = acc[i] ? cfg.cfg_div : pd_q[i];

            run_d[i] = run_q[i];
            n_d[i]   = n_q[i];
            cnt_d[i] = cnt_q[i];
            pv_d[i]  = pvw[i];
            pe_d[i]  = pew[i];
            pd_d[i]  = pdw[i];

            if (!run_q[i]) begin
                cnt_d[i] = '0;
                if (pvw[i]) begin
                    pv_d[i] = 1'b0;
                    if (pew[i]) begin
                        run_d[i] = 1'b1;
                        n_d[i]   = pdw[i];
                    end
                end
            end else if (sync_restart ||
                         cnt_q[i] == n_q[i] - div_t'(1)) begin
                cnt_d[i] = '0;
                if (pvw[i]) begin
                    pv_d[i] = 1'b0;
                    if (pew[i]) n_d[i] = pdw[i];
                    else        run_d[i] = 1'b0;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + div_t'(1);
            end

            hi_d[i]   = (dwx_t'(n_d[i]) + dwx_t'(1)) >> 1;
            clk_d[i]  = run_d[i] && (dwx_t'(cnt_d[i]) < hi_d[i]);
            rise_d[i] = run_d[i] &&
                        ((cnt_d[i] == n_d[i] - div_t'(1) &&
                          !(pv_d[i] && !pe_d[i])) ||
                         (sync_restart && run_q[i]));
            fall_d[i] = run_d[i] && !sync_restart &&
                        (dwx_t'(cnt_d[i]) == hi_d[i] - dwx_t'(1));
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge CLK10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= RST_EN;
            pv_q   <= '0;
            pe_q   <= '0;
            pd_q   <= '0;
            clk_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                n_q[i]   <= RST_N;
                cnt_q[i] <= RST_EN[i] ? RST_HI : '0;
            end
        end else begin
            run_q  <= run_d;
            pv_q   <= pv_d;
            pe_q   <= pe_d;
            pd_q   <= pd_d;
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            err_q  <= rej;
        end
    end

    assign clk_out     = clk_q;
    assign rise_stb    = rise_q;
    assign fall_stb    = fall_q;
    assign active      = run_q;
    assign pending     = pv_q;
    assign cfg.cfg_err = err_q;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: cycle table plus reset/default sequences.
// Expected values are hand-derived per channel and cycle.
module tb_clk_div_bank;
    localparam int NCH  = 4;
    localparam int DIVW = 8;

    logic       CLK10MHZ = 1'b0;
    logic       rst_n = 1'b1;
    logic       sync_restart = 1'b0;
    logic [3:0] clk_out, rise_stb, fall_stb, active, pending;

    int checks = 0;
    int errors = 0;

    clk_div_bank_if #(.NCH(NCH), .DIVW(DIVW)) cfg ();

    clk_div_bank #(
        .NCH(NCH), .DIVW(DIVW), .RST_DIV(10), .RST_EN(4'b0001)
    ) dut (
        .CLK10MHZ(CLK10MHZ),
        .rst_n(rst_n),
        .cfg(cfg),
        .sync_restart(sync_restart),
        .clk_out(clk_out),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb),
        .active(active),
        .pending(pending)
    );

    always #50 CLK10MHZ = ~CLK10MHZ;

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic       en;
        logic       sr;
        logic [3:0] clk;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] act;
        logic [3:0] pend;
        logic       err;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(
        input logic we, input logic [1:0] ch, input logic [7:0] div,
        input logic en, input logic sr,
        input logic [3:0] c, input logic [3:0] r, input logic [3:0] f,
        input logic [3:0] a, input logic [3:0] p, input logic e);
        vec_t v;
        v.we = we; v.ch = ch; v.div = div; v.en = en; v.sr = sr;
        v.clk = c; v.rise = r; v.fall = f; v.act = a; v.pend = p;
        v.err = e;
        return v;
    endfunction

    function automatic logic [20:0] outs();
        return {clk_out, rise_stb, fall_stb, active, pending, cfg.cfg_err};
    endfunction

    task automatic check(input string name, input logic [20:0] got,
                         input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b (clk rise fall act pend err)",
                     name, got, want);
        end
    endtask

    task automatic idle_in();
        cfg.cfg_we   = 1'b0;
        cfg.cfg_ch   = 2'd0;
        cfg.cfg_div  = 8'd0;
        cfg.cfg_en   = 1'b0;
        sync_restart = 1'b0;
    endtask

    initial begin
        //               we ch div en sr  clk     rise    fall    act     pend  err
        tbl[0]  = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0);
        tbl[1]  = mk(1, 1, 3, 1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0011, 4'b0000, 0);
        tbl[3]  = mk(1, 0, 4, 1, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0001, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[5]  = mk(1, 2, 5, 1, 0, 4'b0111, 4'b0000, 4'b0011, 4'b0111, 4'b0000, 0);
        tbl[6]  = mk(1, 2, 6, 1, 0, 4'b0100, 4'b0010, 4'b0000, 4'b0111, 4'b0100, 0);
        tbl[7]  = mk(1, 2, 8, 1, 0, 4'b0110, 4'b0001, 4'b0100, 4'b0111, 4'b0100, 0);
        tbl[8]  = mk(1, 3, 1, 1, 0, 4'b0011, 4'b0000, 4'b0010, 4'b0111, 4'b0100, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 4'b0001, 4'b0110, 4'b0001, 4'b0111, 4'b0100, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 0);
        tbl[11] = mk(1, 2, 0, 0, 0, 4'b0110, 4'b0001, 4'b0010, 4'b0111, 4'b0100, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 4'b0101, 4'b0010, 4'b0000, 4'b0111, 4'b0100, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 4'b0111, 4'b0000, 4'b0101, 4'b0111, 4'b0100, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 4'b0111, 4'b0100, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0011, 4'b0000, 4'b0111, 4'b0100, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0111, 4'b0100, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0111, 4'b0100, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0010, 4'b0011, 4'b0000, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 4'b0001, 4'b0010, 4'b0001, 4'b0011, 4'b0000, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[23] = mk(0, 0, 0, 0, 1, 4'b0011, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 0);
        tbl[24] = mk(0, 0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0011, 4'b0011, 4'b0000, 0);

        idle_in();
        #5 rst_n = 1'b0;
        #5 check("reset_values", outs(), {4'b0000, 4'b0000, 4'b0000,
                                          4'b0001, 4'b0000, 1'b0});
        @(negedge CLK10MHZ);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            cfg.cfg_we   = tbl[i].we;
            cfg.cfg_ch   = tbl[i].ch;
            cfg.cfg_div  = tbl[i].div;
            cfg.cfg_en   = tbl[i].en;
            sync_restart = tbl[i].sr;
            @(posedge CLK10MHZ);
            #1;
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].clk, tbl[i].rise, tbl[i].fall,
                   tbl[i].act, tbl[i].pend, tbl[i].err});
        end
        idle_in();

        #20 rst_n = 1'b0;
        #1 check("async_reset", outs(), {4'b0000, 4'b0000, 4'b0000,
                                         4'b0001, 4'b0000, 1'b0});
        @(negedge CLK10MHZ);
        @(negedge CLK10MHZ);
        rst_n = 1'b1;

        for (int k = 1; k <= 25; k++) begin
            int c;
            logic [3:0] ec, er, ef;
            @(posedge CLK10MHZ);
            #1;
            c  = (5 + k) % 10;
            ec = {3'b000, c < 5};
            er = {3'b000, c == 9};
            ef = {3'b000, c == 4};
            check($sformatf("default_k%0d", k), outs(),
                  {ec, er, ef, 4'b0001, 4'b0000, 1'b0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock divider/enable generator for the CPU clock domain. Derives NCH independent square-wave outputs and single-cycle rise/fall strobes from CLK10MHZ. Each channel's divisor and enable are reprogrammable at run time, with updates applied glitch-free at period boundaries. A global restart phase-aligns all running channels. Channel 0 comes out of reset as the 1 MHz CPU clock.

## Interface
- NCH, 4: number of channels (1..16).
- DIVW, 8: divisor width in bits.
- RST_DIV, 10: divisor loaded into every channel at reset (must be >= 2).
- RST_EN, 1: NCH-bit mask of channels running out of reset.
- CHW, max(1, clog2(NCH)): channel-select width (derived).

- CLK10MHZ  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe, sampled on the CLK10MHZ rising edge.
- cfg_ch  in  CHW  target channel; writes with cfg_ch >= NCH are ignored.
- cfg_div  in  DIVW  new divisor N (period in CLK10MHZ cycles).
- cfg_en  in  1  new enable for the channel.
- sync_restart  in  1  restart all running channels at phase 0.
- clk_out  out  NCH  divided clocks, registered.
- rise_stb  out  NCH  one-cycle pulse in the cycle before clk_out rises.
- fall_stb  out  NCH  one-cycle pulse in the cycle before clk_out falls.
- active  out  NCH  channel running.
- pending  out  NCH  a written config is awaiting application.
- cfg_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- Per-channel state: running, N (active divisor), cnt (0..N-1), pending config (div, en, valid bit).
- hi = (N+1)>>1. While running, clk_out = (cnt < hi): high for ceil(N/2) cycles, low for floor(N/2) cycles, period exactly N.
- While running, each cycle: cnt <= (cnt == N-1) ? 0 : cnt+1. The cycle with cnt == N-1 is the boundary.
- Write handling:
  - A write with cfg_div < 2 and cfg_en = 1 is rejected: cfg_err pulses and state is unchanged.
  - Otherwise the write replaces the channel's pending config (last write wins) and sets pending.
  - cfg_en = 0 ignores cfg_div.
- Applying pending config:
  - Stopped channel: applied at the write edge. If en = 1, then running = 1, N = div, cnt = 0, and clk_out is high in the next cycle. If en = 0, the pending bit simply clears.
  - Running channel: applied at the boundary edge. If en = 1, N takes the new value, cnt = 0, clk_out goes high. If en = 0, running = 0, cnt = 0, clk_out stays 0.
  - A write landing in the boundary cycle is applied at that boundary.
- Stopped channel: clk_out = 0, strobes = 0, cnt held at 0.
- sync_restart: every running channel applies its pending config (if any), then sets cnt = 0 and clk_out = 1 on the next edge, even mid-period. The current period is truncated. Stopped channels are unaffected unless started by a same-cycle write.
- Strobes (registered):
  - rise_stb[i] = running and cnt == N-1 and channel continues running, or sync_restart while running.
  - fall_stb[i] = running and cnt == hi-1, suppressed if sync_restart is asserted.
  - No rise_stb is issued for the first edge after a start from stopped.
- Priority: rst_n > sync_restart > boundary/write.

## Timing
- Reset values:
  - Channels in RST_EN: running = 1, N = RST_DIV, cnt = hi(RST_DIV).
  - Other channels: running = 0, N = RST_DIV, cnt = 0.
  - All outputs: clk_out = 0, strobes = 0, pending = 0, cfg_err = 0; active = RST_EN.
- With defaults, channel 0 is low for 5 cycles after reset release, then toggles every 5 cycles: 1 MHz, 50% duty.
- Start latency: clk_out rises 1 cycle after the accepted write edge.
- Reconfig latency: at most N cycles (next boundary). The output never produces a high or low phase shorter than min(old, new) phase length, except under sync_restart.
- Reset is asynchronous. Assertion mid-period forces reset values immediately, with no completion of the current period.

## Test plan
- Reset release, defaults: clk_out[0] low for 5 cycles, then period 10 with 5 high / 5 low. rise_stb[0] precedes each rise by one cycle. Channels 1-3 stay 0.
- Write ch1, div=3, en=1: clk_out[1] rises next cycle, pattern H,H,L repeating. fall_stb[1] pulses with cnt=1, rise_stb[1] with cnt=2.
- Ch0 running at div 10; write div=4 mid-period: pending=1 and the old period completes. Next period is 2H/2L and pending clears at the boundary.
- Two writes to ch2 (div 6, then div 8) before its boundary: only div 8 is applied. Then write en=0: the channel finishes its period, stays low, and active[2]=0.
- Write div=1, en=1: cfg_err pulses once, and active and pending are unchanged.
- Ch0 div 10 and ch1 div 4, both running; pulse sync_restart: both clk_out go high on the next cycle with simultaneous rise_stb. Assert rst_n low mid-period: all outputs go to reset values immediately.
